// File: rtl/counter_chain_half_duplex_if.sv
// Control/status bundle for the counter chain.
// Master drives the requests, slave returns the chain status.
interface counter_chain_half_duplex_if;
    logic enable;
    logic up_down;
    logic set;
    logic wrap;
    logic at_zero;

    modport master (
        output enable,
        output up_down,
        output set,
        input  wrap,
        input  at_zero
    );

    modport slave (
        input  enable,
        input  up_down,
        input  set,
        output wrap,
        output at_zero
    );
endinterface

// File: rtl/counter_chain_half_duplex.sv
// Cascaded nibble up/down counter chain sharing one half-duplex digit bus.
// Optional macro COUNTER_CHAIN_SATURATE_EN: saturate at the ends, no wrap pulse.
module counter_chain_half_duplex #(
    parameter int          DIGITS    = 4,
    parameter logic [31:0] DIGIT_MAX = 32'h0000_5959
) (
    input  logic                      clk,
    input  logic                      rst,
    counter_chain_half_duplex_if.slave ctl,
    inout  wire  [4*DIGITS-1:0]       number
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] count;
    logic [W-1:0] count_nxt;
    logic [W-1:0] load_val;
    logic         wrap_nxt;
    logic         wrap_r;

    function automatic logic [3:0] max_of(input int i);
        return DIGIT_MAX[4*i +: 4];
    endfunction

    // Bus is released while loading, otherwise shows the live count.
    assign number      = ctl.set ? {W{1'bz}} : count;
    assign ctl.at_zero = (count == '0);
    assign ctl.wrap    = wrap_r;

    // Load value: each bus nibble clamped to its digit's terminal value.
    always_comb begin
        load_val = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (number[4*i +: 4] > max_of(i))
                load_val[4*i +: 4] = max_of(i);
            else
                load_val[4*i +: 4] = number[4*i +: 4];
        end
    end

    // Ripple step: a digit moves only when all lower digits sit at their
    // turn-over value for the current direction.
    always_comb begin
        logic       all_max;
        logic       all_zero;
        logic [3:0] d;
        count_nxt = count;
        all_max   = 1'b1;
        all_zero  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (ctl.up_down) begin
                if (all_max)
                    count_nxt[4*i +: 4] = (d == max_of(i)) ? 4'd0 : d + 4'd1;
            end else begin
                if (all_zero)
                    count_nxt[4*i +: 4] = (d == 4'd0) ? max_of(i) : d - 4'd1;
            end
            all_max  = all_max & (d == max_of(i));
            all_zero = all_zero & (d == 4'd0);
        end
`ifdef COUNTER_CHAIN_SATURATE_EN
        if ((ctl.up_down && all_max) || (!ctl.up_down && all_zero))
            count_nxt = count;
        wrap_nxt = 1'b0;
`else
        wrap_nxt = ctl.up_down ? all_max : all_zero;
`endif
    end

    // Digit register and wrap pulse: rst > set > enable > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wrap_r <= 1'b0;
        end else if (ctl.set) begin
            count  <= load_val;
            wrap_r <= 1'b0;
        end else if (ctl.enable) begin
            count  <= count_nxt;
            wrap_r <= wrap_nxt;
        end else begin
            wrap_r <= 1'b0;
        end
    end
endmodule

// File: doc/counter_chain_half_duplex.md
Name: counter_chain_half_duplex

Overview:
Parametrised multi-digit up/down counter chain for the stopwatch datapath. It generalises the single 4-bit half-duplex counter to DIGITS cascaded nibble digits, each with its own terminal value, so mm:ss, hh:mm and similar formats come from one block. Digit values share one bidirectional bus: the block drives it when reading out and releases it when loading. A registered wrap pulse feeds the next counter stage or the display/alarm logic.

Parameters:
DIGITS, 4, number of nibble digits (1..8); bus width is 4*DIGITS.
DIGIT_MAX, 32'h0000_5959, packed per-digit terminal values; nibble i is the max for digit i; each used nibble must be 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
enable  in  1  count enable, one step per clock when high.
up_down  in  1  1 = count up, 0 = count down.
set  in  1  load request; releases bus and loads it at the clock edge.
number  inout  4*DIGITS  digit bus: driven with count when set=0, high-Z when set=1.
wrap  out  1  registered one-cycle pulse on full-chain wrap.
at_zero  out  1  combinational; high when all digits are 0.

Behaviour:
- Priority at each edge: rst > set > enable > hold.
- rst=1 at an edge: all digits become 0 and wrap becomes 0. Bus stays driven (0) unless set=1. Reset wins over a concurrent set.
- Bus: number = set ? 'bz : count, combinationally, in the same cycle. No registered turnaround.
- set=1 at an edge: digit i loads bus nibble i, clamped to DIGIT_MAX[i] when greater. wrap becomes 0. enable is ignored that cycle.
- Up count (enable=1, set=0, up_down=1):
  - digit 0 steps every edge.
  - digit i steps only when digits 0..i-1 are all at their max.
  - A stepping digit at max becomes 0; otherwise it increments by 1.
- Down count (up_down=0):
  - digit i steps only when digits 0..i-1 are all 0.
  - A stepping digit at 0 becomes its max; otherwise it decrements by 1.
- Full wrap:
  - up from all-max to all-zero, or down from all-zero to all-max.
  - wrap=1 for exactly the one cycle following that edge; 0 otherwise.
- enable=0: digits hold and wrap is 0 the next cycle.
- up_down is sampled per edge. A direction change takes effect at the first edge it is present, with no dead cycle.
- Mid-operation rst (including during set) overrides at that edge; counting resumes from 0 at the next enabled edge.
- at_zero is derived from the registered digits only, independent of set and enable.
- Digit arithmetic is pure per-nibble compare/step; no binary-wide adder.

Optional Feature:
Macro COUNTER_CHAIN_SATURATE_EN.
- Defined:
  - up count at all-max holds at all-max; down count at all-zero holds at all-zero.
  - wrap is never asserted (tied 0).
  - Per-digit ripple is otherwise unchanged, e.g. 0959 up -> 1000.
- Undefined: wrap-around behaviour as in Behaviour.

Test Plan (DIGITS=4, DIGIT_MAX=32'h5959, macro undefined unless stated):
1. rst=1 for one edge after arbitrary count -> number=16'h0000, wrap=0, at_zero=1.
2. From 0000, enable=1, up, 60 edges -> 16'h0100. 3599 edges total -> 16'h5959. Next edge -> 16'h0000 with wrap=1 for one cycle, then 0.
3. set=1 and tb drives 16'h0005 -> number reads z from the DUT during set. After one edge and set=0, DUT drives 16'h0005 and count resumes to 16'h0006.
4. Load 16'h7A9F -> clamped to 16'h5959. Load 16'h3F21 -> 16'h3921.
5. Down from 16'h0100, one edge -> 16'h0059. Down from 16'h0000 -> 16'h5959 with wrap pulse. Toggle up_down mid-run -> direction changes at that same edge.
6. enable=0 for 5 edges -> value held. rst=1 with set=1 at the same edge -> 16'h0000. With COUNTER_CHAIN_SATURATE_EN: up at 5959 holds 5959, down at 0000 holds 0000, wrap stays 0.
